cordic_polar_post: RTL and testbench

CORDIC_POLAR_POST -- requirements
Module: cordic_polar_post

---
 rtl/cordic_polar_post_pkg.sv | 41 ++++
 rtl/cordic_polar_post_if.sv | 31 +++
 rtl/cordic_shift_add_mul.sv | 65 ++++++
 rtl/cordic_polar_post.sv | 118 +++++++++++
 tb/tb_cordic_polar_post.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_polar_post_pkg.sv
// Shared constants for the CORDIC polar post-processing block.
//   - Q12.20 data format widths
//   - CORDIC mode codes (shared with the CORDIC core)
//   - PI in Q12.20 and the per-mode gain-compensation constants
//   - FSM state encoding and a gain lookup helper
package cordic_polar_post_pkg;

  localparam int DATA_W = 32;  // Q12.20 word width
  localparam int FRAC_W = 20;  // fractional bits
  localparam int GAIN_W = 22;  // unsigned gain constant width

  typedef enum logic [1:0] {
    MODE_CIRCULAR   = 2'd0,
    MODE_LINEAR     = 2'd1,
    MODE_HYPERBOLIC = 2'd2,
    MODE_RESERVED   = 2'd3
  } mode_e;

  localparam logic [DATA_W-1:0] PI = 32'h003243F7;

  // 1/K for each mode in Q2.20; LINEAR has unity gain.
  localparam logic [GAIN_W-1:0] GAIN_CIRCULAR   = 22'h09B74F;
  localparam logic [GAIN_W-1:0] GAIN_HYPERBOLIC = 22'h1351E8;
  localparam logic [GAIN_W-1:0] GAIN_LINEAR     = 22'h100000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } state_e;

  // Reserved code falls back to unity gain; the top flags it separately.
  function automatic logic [GAIN_W-1:0] gain_of(input mode_e m);
    case (m)
      MODE_CIRCULAR:   return GAIN_CIRCULAR;
      MODE_HYPERBOLIC: return GAIN_HYPERBOLIC;
      default:         return GAIN_LINEAR;
    endcase
  endfunction

endpackage

// File: rtl/cordic_polar_post_if.sv
// Handshake bus of the CORDIC polar post-processing block.
//   in_valid/in_ready : accept one CORDIC_Vector result (mode, mag_in, angle_in, fold_in)
//   out_valid/out_ready : emit compensated result (mag_out, angle_out, sat_out, mode_err)
// slave  : view used by the block itself
// master : view used by whoever drives inputs and consumes results
interface cordic_polar_post_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [WIDTH-1:0] mag_in;
  logic [WIDTH-1:0] angle_in;
  logic             fold_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] mag_out;
  logic [WIDTH-1:0] angle_out;
  logic             sat_out;
  logic             mode_err;

  modport slave (
    input  in_valid, mode, mag_in, angle_in, fold_in, out_ready,
    output in_ready, out_valid, mag_out, angle_out, sat_out, mode_err
  );

  modport master (
    output in_valid, mode, mag_in, angle_in, fold_in, out_ready,
    input  in_ready, out_valid, mag_out, angle_out, sat_out, mode_err
  );
endinterface

// File: rtl/cordic_shift_add_mul.sv
// Iterative signed x unsigned shift-add multiplier.
//   clock, reset_n : clock and synchronous active-low reset
//   start          : load operand/constant and begin (one-cycle pulse)
//   operand        : signed multiplicand
//   constant       : unsigned multiplier, consumed one bit per cycle, LSB first
//   done           : one-cycle pulse once all CW bits have been consumed
//   product        : signed WIDTH+CW bit result, valid from done onwards
module cordic_shift_add_mul #(
  parameter int WIDTH = 32,
  parameter int CW    = 22
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic signed [WIDTH-1:0]     operand,
  input  logic        [CW-1:0]        constant,
  output logic                        done,
  output logic signed [WIDTH+CW-1:0]  product
);

  localparam int PW    = WIDTH + CW;
  localparam int CNT_W = $clog2(CW);

  logic signed [PW-1:0] mcand;
  logic [CW-1:0]        coef;
  logic [CNT_W-1:0]     count;
  logic                 busy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    // NOTE: datapath registers are reset too; it costs little here and keeps
    // the product deterministic after an abandoned operation.
    if (!reset_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      count   <= '0;
      mcand   <= '0;
      coef    <= '0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        product <= '0;
        mcand   <= {{CW{operand[WIDTH-1]}}, operand};
        coef    <= constant;
        count   <= '0;
        busy    <= 1'b1;
      end else if (busy) begin
        if (coef[0]) begin
          product <= product + mcand;
        end
        mcand <= mcand <<< 1;
        coef  <= coef >> 1;
        if (count == CNT_W'(CW - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cordic_polar_post.sv
// CORDIC polar post-processing: removes the CORDIC gain from the vectoring
// magnitude (iterative multiply by 1/K, floor, saturate) and restores the
// quadrant of the angle when the input vector was folded (x<0).
//   clock, reset_n : clock and synchronous active-low reset
//   bus (slave)    : in_valid/in_ready + mode, mag_in, angle_in, fold_in;
//                    out_valid/out_ready + mag_out, angle_out, sat_out, mode_err
// Latency 23 cycles from the accepting edge; one result in flight at a time.
module cordic_polar_post
  import cordic_polar_post_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int FRAC  = FRAC_W,
  parameter int CW    = GAIN_W
) (
  input  logic                clock,
  input  logic                reset_n,
  cordic_polar_post_if.slave  bus
);

  localparam int PW = WIDTH + CW;

  state_e                   state;
  mode_e                    mode_q;
  logic signed [WIDTH-1:0]  angle_q;
  logic                     fold_q;
  logic [WIDTH-1:0]         mag_q;
  logic [WIDTH-1:0]         angle_o;
  logic                     sat_q;
  logic                     err_q;

  logic                     accept;
  logic                     mul_done;
  logic signed [PW-1:0]     product;
  logic signed [PW-1:0]     shifted;
  logic                     clipped;
  logic [WIDTH-1:0]         mag_sat;
  logic [WIDTH-1:0]         angle_fix;

  assign accept        = bus.in_valid && (state == ST_IDLE);
  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.mag_out   = mag_q;
  assign bus.angle_out = angle_o;
  assign bus.sat_out   = sat_q;
  assign bus.mode_err  = err_q;

  // The multiplier captures mag_in itself on the accepting edge.
  cordic_shift_add_mul #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_mul (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (accept),
    .operand  ($signed(bus.mag_in)),
    .constant (CW'(gain_of(mode_e'(bus.mode)))),
    .done     (mul_done),
    .product  (product)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    // Floor division by 2^FRAC; the result fits WIDTH bits only when all bits
    // from WIDTH-1 upward agree with the sign.
    shifted = product >>> FRAC;
    clipped = !((&shifted[PW-1:WIDTH-1]) || !(|shifted[PW-1:WIDTH-1]));
    mag_sat = shifted[WIDTH-1:0];
    if (clipped) begin
      mag_sat = shifted[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    // A folded input was rotated by PI; undo it, keeping the angle in (-PI, PI].
    angle_fix = angle_q;
    if (mode_q == MODE_CIRCULAR && fold_q) begin
      angle_fix = (angle_q <= 0) ? angle_q + WIDTH'(PI) : angle_q - WIDTH'(PI);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_CIRCULAR;
      angle_q <= '0;
      fold_q  <= 1'b0;
      mag_q   <= '0;
      angle_o <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            mode_q  <= mode_e'(bus.mode);
            angle_q <= bus.angle_in;
            fold_q  <= bus.fold_in;
            state   <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            mag_q   <= mag_sat;
            sat_q   <= clipped;
            angle_o <= angle_fix;
            err_q   <= (mode_q == MODE_RESERVED);
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_polar_post.sv
// Self-checking bench for cordic_polar_post: a cycle-level reference model
// (plain 64-bit arithmetic) checked every cycle, plus directed vectors with
// hand-computed results.
module tb_cordic_polar_post;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  cordic_polar_post_if #(.WIDTH(32)) bus ();

  cordic_polar_post #(
    .WIDTH (32),
    .FRAC  (20),
    .CW    (22)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: magnitude * (1/K), floor by 2^20, clip to 32-bit signed;
  // angle shifted back by PI when a circular input was folded.
  function automatic void model(input logic [1:0] m, input logic [31:0] mag,
                                input logic [31:0] ang, input logic f,
                                output logic [31:0] om, output logic [31:0] oa,
                                output logic os, output logic oe);
    longint g;
    longint p;
    longint q;
    case (m)
      2'd0:    g = 64'h09B74F;
      2'd2:    g = 64'h1351E8;
      default: g = 64'h100000;
    endcase
    p = longint'($signed(mag)) * g;
    q = p >>> 20;
    if (q > 64'sd2147483647) begin
      om = 32'h7FFFFFFF; os = 1'b1;
    end else if (q < -64'sd2147483648) begin
      om = 32'h80000000; os = 1'b1;
    end else begin
      om = q[31:0]; os = 1'b0;
    end
    oe = (m == 2'd3);
    oa = ang;
    if (m == 2'd0 && f) begin
      if ($signed(ang) <= 0) oa = ang + 32'h003243F7;
      else                   oa = ang - 32'h003243F7;
    end
  endfunction

  // Scoreboard: one result in flight; out_valid expected from the 24th
  // negedge after the accept negedge (23 edges after the accepting edge).
  bit          pend = 1'b0;
  int          age  = 0;
  logic [31:0] em, ea;
  logic        es, ee;

  always @(negedge clock) begin
    bit exp_valid;
    if (started) begin
      if (pend) age++;
      exp_valid = pend && (age >= 24);
      check("sb_in_ready", {31'd0, bus.in_ready}, {31'd0, !pend});
      check("sb_out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
      if (exp_valid && bus.out_valid) begin
        check("sb_mag", bus.mag_out, em);
        check("sb_angle", bus.angle_out, ea);
        check("sb_sat", {31'd0, bus.sat_out}, {31'd0, es});
        check("sb_err", {31'd0, bus.mode_err}, {31'd0, ee});
      end
      if (!reset_n) begin
        pend = 1'b0;
      end else if (exp_valid && bus.out_ready) begin
        pend = 1'b0;
      end else if (!pend && bus.in_valid) begin
        model(bus.mode, bus.mag_in, bus.angle_in, bus.fold_in, em, ea, es, ee);
        pend = 1'b1;
        age  = 0;
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic [31:0] mag, input logic [31:0] ang,
                      input logic f, input int hold,
                      input logic [31:0] xm, input logic [31:0] xa, input logic xs, input logic xe);
    bit seen;
    int k;
    @(posedge clock); #1;
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.mode      = m;
    bus.mag_in    = mag;
    bus.angle_in  = ang;
    bus.fold_in   = f;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      seen = bus.in_ready;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL accept_timeout got=0 exp=1");
    end
    @(posedge clock); #1;
    // Post-accept changes must not leak into the result.
    bus.in_valid = 1'b0;
    bus.mode     = ~m;
    bus.mag_in   = 32'hDEADBEEF;
    bus.angle_in = ~ang;
    bus.fold_in  = ~f;
    seen = 1'b0;
    k = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      k++;
      seen = bus.out_valid;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL result_timeout got=0 exp=1");
    end else begin
      check("latency", k - 1, 32'd23);
      check("mag", bus.mag_out, xm);
      check("angle", bus.angle_out, xa);
      check("sat", {31'd0, bus.sat_out}, {31'd0, xs});
      check("mode_err", {31'd0, bus.mode_err}, {31'd0, xe});
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clock);
      check("hold_mag", bus.mag_out, xm);
      check("hold_angle", bus.angle_out, xa);
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clock); #1;
      bus.out_ready = 1'b1;
      @(negedge clock);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.mode      = 2'd0;
    bus.mag_in    = '0;
    bus.angle_in  = '0;
    bus.fold_in   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_mag", bus.mag_out, 32'd0);
    check("rst_angle", bus.angle_out, 32'd0);
    check("rst_sat", {31'd0, bus.sat_out}, 32'd0);
    check("rst_err", {31'd0, bus.mode_err}, 32'd0);
    started = 1'b1;

    // Circular, unfolded: 1.6467603 * 1/K ~ 1.0
    send(2'd0, 32'h001A5926, 32'h000C90FE, 1'b0, 0, 32'h00100003, 32'h000C90FE, 1'b0, 1'b0);
    // Circular, folded: positive angle -> angle - PI, non-positive -> angle + PI
    send(2'd0, 32'h001A5926, 32'h000C90FE, 1'b1, 0, 32'h00100003, 32'hFFDA4D07, 1'b0, 1'b0);
    send(2'd0, 32'h001A5926, 32'hFFF36F02, 1'b1, 0, 32'h00100003, 32'h0025B2F9, 1'b0, 1'b0);
    send(2'd0, 32'h001A5926, 32'h00000000, 1'b1, 0, 32'h00100003, 32'h003243F7, 1'b0, 1'b0);
    // Negative magnitude rounds toward minus infinity
    send(2'd0, 32'hFFE5A6DA, 32'h00010000, 1'b0, 0, 32'hFFEFFFFC, 32'h00010000, 1'b0, 1'b0);
    // Linear and reserved: unity gain, no angle fix even with fold set
    send(2'd1, 32'h00200000, 32'h12345678, 1'b1, 0, 32'h00200000, 32'h12345678, 1'b0, 1'b0);
    send(2'd3, 32'h00200000, 32'h12345678, 1'b1, 0, 32'h00200000, 32'h12345678, 1'b0, 1'b1);
    // Hyperbolic saturation in both directions
    send(2'd2, 32'h7FFFFFFF, 32'h00001000, 1'b1, 0, 32'h7FFFFFFF, 32'h00001000, 1'b1, 1'b0);
    send(2'd2, 32'h80000000, 32'hFFFFF000, 1'b0, 0, 32'h80000000, 32'hFFFFF000, 1'b1, 1'b0);
    // Back-pressure for 10 cycles, then an immediate follow-up transaction
    send(2'd1, 32'hFFF00000, 32'h00000123, 1'b0, 10, 32'hFFF00000, 32'h00000123, 1'b0, 1'b0);
    send(2'd0, 32'h001A5926, 32'h000C90FE, 1'b0, 0, 32'h00100003, 32'h000C90FE, 1'b0, 1'b0);

    // Reset in the 10th cycle of MUL abandons the operation
    @(posedge clock); #1;
    bus.in_valid = 1'b1;
    bus.mode     = 2'd2;
    bus.mag_in   = 32'h00300000;
    bus.angle_in = 32'h00000777;
    bus.fold_in  = 1'b0;
    @(negedge clock);
    check("pre_rst_accept", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_mag", bus.mag_out, 32'd0);
    check("mid_rst_angle", bus.angle_out, 32'd0);
    check("mid_rst_sat", {31'd0, bus.sat_out}, 32'd0);
    check("mid_rst_err", {31'd0, bus.mode_err}, 32'd0);
    repeat (40) @(negedge clock);

    // Normal operation resumes after the abandoned transaction
    send(2'd1, 32'h00200000, 32'h00000042, 1'b0, 0, 32'h00200000, 32'h00000042, 1'b0, 1'b0);
    repeat (3) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
